// File: rtl/fpu_pkg.sv
// Shared definitions for the multi-cycle FP add/sub unit: FSM encoding,
// flag bit positions and the canonical quiet-NaN pattern.
package fpu_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;

  localparam int FL_INV = 3;
  localparam int FL_OVF = 2;
  localparam int FL_UNF = 1;
  localparam int FL_INX = 0;

  // sign 0, exponent all-ones, fraction MSB set
  function automatic logic [63:0] qnan_bits(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports IN_W.
module fp_lzc #(
  parameter int IN_W  = 24,
  parameter int CNT_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  i_val,
  output logic [CNT_W-1:0] o_cnt
);
  always_comb begin
    o_cnt = CNT_W'(IN_W);
    for (int i = 0; i < IN_W; i++)
      if (i_val[i]) o_cnt = CNT_W'(IN_W - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_mc.sv
// Multi-cycle IEEE-style add/subtract: IDLE->ALIGN->ADD->NORM->ROUND, RNE,
// subnormals flushed to zero.
module fp_addsub_mc
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   opcode,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   ready,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden bit + fraction + guard/round/sticky
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 2);
  localparam logic [W-1:0]     QNAN = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] EMAX = '1;

  logic [2:0]           r_state;
  logic [W-1:0]         r_a, r_b, r_spec_res, r_res;
  logic                 r_op, r_spec, r_sign, r_sub, r_zero, r_done;
  logic [3:0]           r_spec_fl, r_fl;
  logic signed [XW-1:0] r_exp;
  logic [SW-1:0]        r_xs, r_ys, r_norm;
  logic [SW:0]          r_sum;

  logic                 w_sa, w_sb, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_a_big, w_spec;
  logic [EXP_W-1:0]     w_ea, w_eb, w_ex, w_ey, w_d;
  logic [MAN_W-1:0]     w_fa, w_fb, w_fx, w_fy, w_frac;
  logic [SW-1:0]        w_yfull, w_mask, w_ys, w_norm;
  logic [W-1:0]         w_spec_res, w_res;
  logic [3:0]           w_spec_fl, w_fl;
  logic [CW-1:0]        w_lzc;
  logic signed [XW-1:0] w_nexp, w_rexp;
  logic [MAN_W+1:0]     w_mr;
  logic                 w_up, w_inx;

  assign ready  = (r_state == ST_IDLE);
  assign done   = r_done;
  assign result = r_res;
  assign flags  = r_fl;

  // ALIGN: decode, special operands, magnitude compare, shift smaller operand
  assign w_sa    = r_a[W-1];
  assign w_ea    = r_a[W-2 -: EXP_W];
  assign w_fa    = r_a[MAN_W-1:0];
  assign w_sb    = r_b[W-1] ^ r_op;
  assign w_eb    = r_b[W-2 -: EXP_W];
  assign w_fb    = r_b[MAN_W-1:0];
  assign w_nan_a = (w_ea == EMAX) && (w_fa != '0);
  assign w_nan_b = (w_eb == EMAX) && (w_fb != '0);
  assign w_inf_a = (w_ea == EMAX) && (w_fa == '0);
  assign w_inf_b = (w_eb == EMAX) && (w_fb == '0);
  assign w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
  assign w_ex    = w_a_big ? w_ea : w_eb;
  assign w_ey    = w_a_big ? w_eb : w_ea;
  assign w_fx    = w_a_big ? w_fa : w_fb;
  assign w_fy    = w_a_big ? w_fb : w_fa;
  assign w_d     = w_ex - w_ey;
  assign w_yfull = {1'b1, w_fy, 3'b000};
  assign w_mask  = ~({SW{1'b1}} << w_d);
  assign w_ys    = (32'(w_d) >= MAN_W + 3) ? SW'(1)
                 : ((w_yfull >> w_d) | SW'(|(w_yfull & w_mask)));

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = r_a;
    w_spec_fl  = '0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) begin
      w_spec_res        = QNAN;
      w_spec_fl[FL_INV] = 1'b1;
    end else if (w_inf_a)    w_spec_res = r_a;
    else if (w_inf_b)        w_spec_res = {w_sb, w_eb, w_fb};
    else if (w_eb == '0)     w_spec_res = r_a;
    else if (w_ea == '0)     w_spec_res = {w_sb, w_eb, w_fb};
    else                     w_spec     = 1'b0;
  end

  // NORM: carry shifts right into sticky, otherwise left by leading zeros
  fp_lzc #(.IN_W(MAN_W + 1), .CNT_W(CW)) u_lzc (
    .i_val (r_sum[SW-1:3]),
    .o_cnt (w_lzc)
  );
  assign w_norm = r_sum[SW] ? {r_sum[SW:2], r_sum[1] | r_sum[0]} : (r_sum[SW-1:0] << w_lzc);
  assign w_nexp = r_sum[SW] ? r_exp + XW'(1) : r_exp - XW'(w_lzc);

  // ROUND: nearest-even on guard/round/sticky, then range checks
  assign w_up   = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
  assign w_inx  = |r_norm[2:0];
  assign w_mr   = {1'b0, r_norm[SW-1:3]} + (MAN_W+2)'(w_up);
  assign w_rexp = r_exp + XW'(w_mr[MAN_W+1]);
  assign w_frac = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

  always_comb begin
    w_res = {r_sign, w_rexp[EXP_W-1:0], w_frac};
    w_fl  = '0;
    if (r_spec) begin
      w_res = r_spec_res;
      w_fl  = r_spec_fl;
    end else if (r_zero) begin
      w_res = '0;
    end else if (w_rexp <= 0) begin
      w_res         = {r_sign, {(W-1){1'b0}}};
      w_fl[FL_UNF]  = 1'b1;
      w_fl[FL_INX]  = 1'b1;
    end else if (w_rexp >= $signed(XW'(EMAX))) begin
      w_res         = {r_sign, EMAX, {MAN_W{1'b0}}};
      w_fl[FL_OVF]  = 1'b1;
      w_fl[FL_INX]  = 1'b1;
    end else begin
      w_fl[FL_INX]  = w_inx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_fl    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_op    <= opcode;
          r_state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_fl  <= w_spec_fl;
          r_sign     <= w_a_big ? w_sa : w_sb;
          r_sub      <= w_sa ^ w_sb;
          r_exp      <= XW'(w_ex);
          r_xs       <= {1'b1, w_fx, 3'b000};
          r_ys       <= w_ys;
          r_state    <= ST_ADD;
        end
        ST_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_xs} - {1'b0, r_ys}) : ({1'b0, r_xs} + {1'b0, r_ys});
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          r_norm  <= w_norm;
          r_exp   <= w_nexp;
          r_zero  <= (r_sum == '0);
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_res   <= w_res;
          r_fl    <= w_fl;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_mc.sv
// Scoreboard bench for fp_addsub_mc: single- and half-precision instances,
// exact big-integer reference model, decoupled result monitors.
module tb_fp_addsub_mc;
  typedef struct {
    logic [63:0] res;
    logic [3:0]  fl;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, opcode = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, done;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        h_start = 1'b0, h_opcode = 1'b0;
  logic [15:0] h_a = '0, h_b = '0;
  logic        h_ready, h_done;
  logic [15:0] h_result;
  logic [3:0]  h_flags;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q16[$];

  fp_addsub_mc u_dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .flags(flags)
  );

  fp_addsub_mc #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(rst), .start(h_start), .opcode(h_opcode), .a(h_a), .b(h_b),
    .ready(h_ready), .done(h_done), .result(h_result), .flags(h_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic chk_fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", nm, cyc);
  endtask

  // Exact reference: operands become integers in units of the smallest
  // normal ulp, are summed exactly, then rounded to MAN_W+1 significant bits.
  function automatic void ref_model(input int ew, input int mw, input logic [63:0] x,
                                    input logic [63:0] y, input bit op,
                                    output logic [63:0] r, output logic [3:0] f);
    int          emax = (1 << ew) - 1;
    bit          sx = x[ew+mw];
    bit          sy = y[ew+mw] ^ op;
    int          ex = int'((x >> mw) & 64'(emax));
    int          ey = int'((y >> mw) & 64'(emax));
    logic [63:0] fmask = (64'd1 << mw) - 64'd1;
    logic [63:0] fx = x & fmask;
    logic [63:0] fy = y & fmask;
    logic [63:0] sbit = 64'd1 << (ew + mw);
    logic [319:0] vx, vy, mag, m, rem, half;
    bit          s, inx;
    int          p, sh, e;
    r = '0;
    f = '0;
    if ((ex == emax && fx != 0) || (ey == emax && fy != 0) || (ex == emax && ey == emax && sx != sy)) begin
      r = (64'(emax) << mw) | (64'd1 << (mw - 1));
      f = 4'b1000;
      return;
    end
    if (ex == emax) begin r = x; return; end
    if (ey == emax) begin r = (sy ? sbit : 64'd0) | (64'(ey) << mw) | fy; return; end
    if (ey == 0) begin r = x; return; end
    if (ex == 0) begin r = (sy ? sbit : 64'd0) | (64'(ey) << mw) | fy; return; end
    vx = 320'(fx | (64'd1 << mw)) << (ex - 1);
    vy = 320'(fy | (64'd1 << mw)) << (ey - 1);
    if (sx == sy)      begin mag = vx + vy; s = sx; end
    else if (vx > vy)  begin mag = vx - vy; s = sx; end
    else if (vy > vx)  begin mag = vy - vx; s = sy; end
    else return;
    p = 0;
    for (int i = 319; i >= 0; i--) if (mag[i]) begin p = i; break; end
    sh  = p - mw;
    e   = p - mw + 1;
    inx = 1'b0;
    if (sh > 0) begin
      m    = mag >> sh;
      rem  = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && m[0])) m = m + 320'd1;
      if (m == (320'd1 << (mw + 1))) begin m = m >> 1; e++; end
    end else begin
      m = mag << (-sh);
    end
    if (e <= 0) begin
      r = s ? sbit : 64'd0;
      f = 4'b0011;
    end else if (e >= emax) begin
      r = (s ? sbit : 64'd0) | (64'(emax) << mw);
      f = 4'b0101;
    end else begin
      r = (s ? sbit : 64'd0) | (64'(e) << mw) | (64'(m) & fmask);
      f = {3'b000, inx};
    end
  endfunction

  function automatic logic [63:0] rnd_op(input int ew, input int mw, input int ebase);
    int          emax = (1 << ew) - 1;
    int          k = int'($urandom_range(0, 99));
    int          e;
    logic [63:0] f = {32'd0, $urandom} & ((64'd1 << mw) - 64'd1);
    if (k < 4)       begin e = 0; f = '0; end
    else if (k < 7)  begin e = emax; f = '0; end
    else if (k < 9)  begin e = emax; if (f == 0) f = 64'd1; end
    else if (k < 60) begin
      e = ebase + int'($urandom_range(0, 6)) - 3;
      if (e < 1) e = 1;
      if (e > emax - 1) e = emax - 1;
    end else e = int'($urandom_range(1, emax - 1));
    return (64'($urandom_range(0, 1)) << (ew + mw)) | (64'(e) << mw) | f;
  endfunction

  // Entered and left on a falling edge; expected done is 5 cycles after issue.
  task automatic send(input bit hp, input logic [63:0] ta, input logic [63:0] tb, input bit op,
                      input bit use_k, input logic [63:0] kres, input logic [3:0] kfl,
                      input bit push);
    int   n = 0;
    exp_t e;
    while (!(hp ? h_ready : ready) && n < 20) begin @(negedge clk); n++; end
    if (!(hp ? h_ready : ready)) begin chk_fail("ready_timeout"); return; end
    if (use_k) begin e.res = kres; e.fl = kfl; end
    else if (hp) ref_model(5, 10, ta, tb, op, e.res, e.fl);
    else         ref_model(8, 23, ta, tb, op, e.res, e.fl);
    e.cyc = cyc + 5;
    if (hp) begin h_a = ta[15:0]; h_b = tb[15:0]; h_opcode = op; h_start = 1'b1; end
    else    begin a = ta[31:0];   b = tb[31:0];   opcode = op;   start = 1'b1;   end
    if (push) begin
      if (hp) q16.push_back(e);
      else    q32.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    h_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 40) begin @(negedge clk); n++; end
    if (q32.size() != 0 || q16.size() != 0) begin
      chk_fail("drain_timeout");
      q32.delete();
      q16.delete();
    end
  endtask

  initial begin : mon32
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q32.size() == 0) chk_fail("spurious_done32");
        else begin
          e = q32.pop_front();
          chk("res32", 64'(result), e.res);
          chk("flags32", 64'(flags), 64'(e.fl));
          chk("latency32", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      if (h_done === 1'b1) begin
        if (q16.size() == 0) chk_fail("spurious_done16");
        else begin
          e = q16.pop_front();
          chk("res16", 64'(h_result), e.res);
          chk("flags16", 64'(h_flags), 64'(e.fl));
          chk("latency16", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : stim
    logic [63:0] ta, tb;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_h_ready", 64'(h_ready), 64'd1);
    chk("rst_h_result", 64'(h_result), 64'd0);
    rst = 1'b0;

    // back-to-back pair first: the second start lands in the done cycle
    send(0, 64'h3F800000, 64'h3F800000, 1'b0, 1, 64'h40000000, 4'b0000, 1);
    send(0, 64'h40400000, 64'h40400000, 1'b1, 1, 64'h00000000, 4'b0000, 1);
    send(0, 64'h3F800000, 64'h33800000, 1'b0, 1, 64'h3F800000, 4'b0001, 1);
    send(0, 64'h3F800001, 64'h33800000, 1'b0, 1, 64'h3F800002, 4'b0001, 1);
    send(0, 64'h7F7FFFFF, 64'h7F7FFFFF, 1'b0, 1, 64'h7F800000, 4'b0101, 1);
    send(0, 64'h00800000, 64'h00800001, 1'b1, 1, 64'h80000000, 4'b0011, 1);
    send(0, 64'h7F800000, 64'h7F800000, 1'b1, 1, 64'h7FC00000, 4'b1000, 1);
    send(0, 64'h7FC00001, 64'h3F800000, 1'b0, 1, 64'h7FC00000, 4'b1000, 1);
    send(0, 64'hFF800000, 64'h3F800000, 1'b0, 1, 64'hFF800000, 4'b0000, 1);
    send(0, 64'hC0A00000, 64'h00000000, 1'b1, 1, 64'hC0A00000, 4'b0000, 1);
    drain();

    // starts while busy must be ignored
    send(0, 64'h3F800000, 64'h40000000, 1'b0, 1, 64'h40400000, 4'b0000, 1);
    repeat (3) begin
      a = $urandom; b = $urandom; opcode = 1'b1; start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("hold_result", 64'(result), 64'h40400000);

    // reset while in NORM discards the operation
    send(0, 64'h40A00000, 64'h3F800000, 1'b0, 0, 64'd0, 4'd0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_flags", 64'(flags), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      ta = rnd_op(8, 23, int'($urandom_range(1, 254)));
      if ($urandom_range(0, 9) == 0) tb = ta ^ (64'($urandom_range(0, 1)) << 31);
      else tb = rnd_op(8, 23, int'((ta >> 23) & 64'hFF));
      send(0, ta, tb, 1'($urandom_range(0, 1)), 0, 64'd0, 4'd0, 1);
    end
    drain();

    send(1, 64'h3C00, 64'h3C00, 1'b0, 1, 64'h4000, 4'b0000, 1);
    send(1, 64'h3C00, 64'h4000, 1'b1, 1, 64'hBC00, 4'b0000, 1);
    send(1, 64'h7BFF, 64'h7BFF, 1'b0, 1, 64'h7C00, 4'b0101, 1);
    for (int i = 0; i < 200; i++) begin
      ta = rnd_op(5, 10, int'($urandom_range(1, 30)));
      if ($urandom_range(0, 9) == 0) tb = ta ^ (64'($urandom_range(0, 1)) << 15);
      else tb = rnd_op(5, 10, int'((ta >> 10) & 64'h1F));
      send(1, ta, tb, 1'($urandom_range(0, 1)), 0, 64'd0, 4'd0, 1);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_addsub_mc.md
FP_ADDSUB_MC -- requirements
Module: fp_addsub_mc

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (allowed range 4..11).
REQ-002 Parameter MAN_W, default 23, stored fraction width (allowed range 4..52). Local W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only when ready=1.
REQ-006 opcode  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a, b  input  W each  IEEE-style operands {sign, exponent, fraction}; sampled with start.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  one-cycle pulse when result/flags update.
REQ-010 result  output  W  registered result; holds until next done.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}; registered with result.

Function
REQ-012 FSM states IDLE→ALIGN→ADD→NORM→ROUND→IDLE; leave IDLE only on start=1; every other state advances unconditionally.
REQ-013 start is accepted in the cycle where ready=1; operands/opcode are captured at that edge; start while ready=0 is ignored.
REQ-014 done=1 and result valid in the 5th cycle after the accepting edge (i.e. the first IDLE cycle after ROUND); a start in that same cycle is accepted (5-cycle throughput).
REQ-015 ALIGN: full magnitude compare (exponent, then significand); larger magnitude becomes operand X, result sign = sign of X (sign of b inverted when opcode=1).
REQ-016 Smaller significand is right-shifted by the exponent difference into guard, round and sticky bits; difference ≥ MAN_W+3 yields all-zero shifted value with sticky = OR of the discarded significand.
REQ-017 ADD: effective add if signs equal, else X−Y; difference never negative by REQ-015.
REQ-018 NORM: carry-out gives right shift by 1 (exponent+1, shifted bit joins sticky); otherwise left shift by leading-zero count, exponent reduced accordingly.
REQ-019 ROUND: round-to-nearest-even on guard/round/sticky; mantissa overflow from rounding renormalises and increments exponent; inexact=1 whenever any of guard/round/sticky is nonzero.
REQ-020 Exponent field 0 inputs are treated as ±0 (subnormals flushed); a±0 returns a exactly (sign per opcode).
REQ-021 Exact cancellation returns +0, flags 0.
REQ-022 Result exponent ≤ 0 after normalise/round returns signed zero with underflow=1, inexact=1.
REQ-023 Result exponent ≥ all-ones returns signed infinity with overflow=1, inexact=1.
REQ-024 Any NaN input, or inf−inf effective subtract, returns canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0) with invalid=1; inf with finite returns that inf, flags 0.
REQ-025 Internal datapath widths derive only from EXP_W/MAN_W; exponent arithmetic uses EXP_W+2 bits signed to detect over/underflow.

Reset
REQ-026 rst=1 at an edge forces IDLE, ready=1, done=0, result=0, flags=0, regardless of state; an in-flight operation is discarded and never signals done.
REQ-027 rst has priority over start in the same cycle.

Structure
REQ-028 Shared package fpu_pkg holds the FSM state encoding, flag bit indices and the canonical-qNaN constant function of EXP_W/MAN_W.
REQ-029 Leading-zero counting is a separate parametrised sub-module fp_lzc (input width MAN_W+1, count output width clog2(MAN_W+2)); alignment/normalise shifts are inline.

Verification
REQ-030 0x3F800000 + 0x3F800000, opcode 0 → result 0x40000000, flags 0, done exactly 5 cycles after accepting edge; back-to-back start in the done cycle accepted.
REQ-031 0x40400000 − 0x40400000 → 0x00000000, flags 0; 0x3F800000 + 0x33800000 → 0x3F800000 inexact=1; 0x3F800001 + 0x33800000 → 0x3F800002 inexact=1.
REQ-032 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1; 0x00800000 − 0x00800001 → 0x80000000, underflow=1.
REQ-033 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1; 0x7FC00001 + 0x3F800000 → 0x7FC00000, invalid=1; 0xFF800000 + 0x3F800000 → 0xFF800000, flags 0.
REQ-034 rst asserted during NORM → next cycle ready=1, result=0, no done pulse; start asserted while busy → ignored, original result unchanged.
REQ-035 EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000; 0x3C00 − 0x4000 → 0xBC00; 0x7BFF + 0x7BFF → 0x7C00 overflow=1.
